// File: rtl/core_boot_loader_pkg.sv
// Shared types for the boot loader: network packet and memory request layouts,
// boot FSM states and small helpers.
package core_boot_loader_pkg;

  localparam int unsigned rs_imm_size_gp = 6;

  typedef enum logic [2:0] {
    NetNull  = 3'd0,
    NetInstr = 3'd1,
    NetReg   = 3'd2,
    NetPc    = 3'd3,
    NetBar   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  id;
    net_op_e     net_op;
    logic [3:0]  reserved;
    logic [31:0] net_data;
    logic [9:0]  net_addr;
  } net_packet_s;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  typedef enum logic [2:0] {
    StIdle,
    StLoadD,
    StDEnd,
    StInstr,
    StReg,
    StBar,
    StPc,
    StDone
  } boot_state_e;

  localparam logic [31:0] boot_null_data_gp = 32'hFFFFFFFE;

  // ROM address width; a one-word image still gets a 1-bit address.
  function automatic int unsigned boot_addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic net_packet_s boot_make_pkt(input logic [9:0]  id,
                                                input net_op_e     op,
                                                input logic [31:0] data,
                                                input logic [9:0]  addr);
    net_packet_s p;
    p          = '0;
    p.id       = id;
    p.net_op   = op;
    p.net_data = data;
    p.net_addr = addr;
    return p;
  endfunction

endpackage

// File: rtl/core_boot_loader_stream_ctr.sv
// Per-image ROM streaming counter: read address, the index of the word whose
// data is currently on the ROM output, and a last-word flag.
module boot_stream_ctr
  import core_boot_loader_pkg::*;
#(
  parameter int unsigned Len = 4,
  localparam int unsigned Aw = boot_addr_w(Len)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [Aw-1:0] rd_addr,
  output logic [Aw:0]   idx,
  output logic          last
);

  localparam int unsigned LastInt = Len - 1;
  localparam logic [Aw:0] LastIdx = LastInt[Aw:0];

  logic [Aw:0] rd_q, rd_d;
  logic [Aw:0] idx_q, idx_d;
  logic        unused_rd_msb;

  // Next read address; idx follows one cycle behind to match the ROM latency.
  always_comb begin
    rd_d  = rd_q;
    idx_d = rd_q;
    if (clr) begin
      rd_d  = '0;
      idx_d = '0;
    end else if (adv && (rd_q != LastIdx)) begin
      rd_d = rd_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      idx_q <= '0;
    end else begin
      rd_q  <= rd_d;
      idx_q <= idx_d;
    end
  end

  assign rd_addr       = rd_q[Aw-1:0];
  assign idx           = idx_q;
  assign last          = (idx_q == LastIdx);
  assign unused_rd_msb = rd_q[Aw];

endmodule

// File: rtl/core_boot_loader.sv
// Boot sequencer for one core: writes the data image into data memory, then
// streams instruction, register, barrier-mask, PC and NULL packets to the core.
module core_boot_loader
  import core_boot_loader_pkg::*;
#(
  parameter int unsigned INSTR_WORDS_P = 1024,
  parameter int unsigned DATA_WORDS_P  = 1024,
  parameter int unsigned REG_WORDS_P   = 64,
  parameter logic [9:0]  CORE_ID_P     = 10'd1,
  parameter logic [31:0] BAR_MASK_P    = 32'h2,
  parameter logic [9:0]  BAR_ADDR_P    = 10'd24,
  parameter logic [31:0] START_PC_P    = 32'h5,
  localparam int unsigned InstrAw = boot_addr_w(INSTR_WORDS_P),
  localparam int unsigned DataAw  = boot_addr_w(DATA_WORDS_P),
  localparam int unsigned RegAw   = boot_addr_w(REG_WORDS_P)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_i,
  output logic [InstrAw-1:0]          instr_rom_addr_o,
  input  logic [15:0]                 instr_rom_data_i,
  output logic [DataAw-1:0]           data_rom_addr_o,
  input  logic [31:0]                 data_rom_data_i,
  output logic [RegAw-1:0]            reg_rom_addr_o,
  input  logic [39:0]                 reg_rom_data_i,
  output logic [$bits(mem_in_s)-1:0]  mem_flat_o,
  output logic [31:0]                 mem_addr_o,
  output logic                        mem_sel_o,
  output logic [$bits(net_packet_s)-1:0] net_packet_flat_o,
  output logic                        busy_o,
  output logic                        done_o
);

  boot_state_e state_q, state_d;
  logic        phase_q, phase_d;
  net_packet_s packet_q, packet_d;
  mem_in_s     mem_q, mem_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_sel_q, mem_sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic              data_clr, data_adv, data_last;
  logic              instr_clr, instr_adv, instr_last;
  logic              reg_clr, reg_adv, reg_last;
  logic [DataAw:0]   data_idx;
  logic [InstrAw:0]  instr_idx;
  logic [RegAw:0]    reg_idx;
  logic              unused_bits;

  boot_stream_ctr #(.Len(DATA_WORDS_P)) u_data_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (data_clr),
    .adv    (data_adv),
    .rd_addr(data_rom_addr_o),
    .idx    (data_idx),
    .last   (data_last)
  );

  boot_stream_ctr #(.Len(INSTR_WORDS_P)) u_instr_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (instr_clr),
    .adv    (instr_adv),
    .rd_addr(instr_rom_addr_o),
    .idx    (instr_idx),
    .last   (instr_last)
  );

  boot_stream_ctr #(.Len(REG_WORDS_P)) u_reg_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (reg_clr),
    .adv    (reg_adv),
    .rd_addr(reg_rom_addr_o),
    .idx    (reg_idx),
    .last   (reg_last)
  );

  // Next-state, counter control and next registered outputs.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    packet_d   = '0;
    mem_d      = '0;
    mem_addr_d = '0;
    mem_sel_d  = mem_sel_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    data_clr   = 1'b0;
    data_adv   = 1'b0;
    instr_clr  = 1'b0;
    instr_adv  = 1'b0;
    reg_clr    = 1'b0;
    reg_adv    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoadD;
          phase_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StLoadD: begin
        // Phase 0 writes the word on the ROM bus; phase 1 waits for the next read.
        busy_d  = 1'b1;
        phase_d = ~phase_q;
        if (!phase_q) begin
          mem_d.valid         = 1'b1;
          mem_d.yumi          = 1'b1;
          mem_d.wen           = 1'b1;
          mem_d.byte_not_word = 1'b0;
          mem_d.write_data    = data_rom_data_i;
          mem_addr_d          = 32'(data_idx) << 2;
          data_adv            = 1'b1;
        end else if (data_last) begin
          data_clr = 1'b1;
          state_d  = StDEnd;
        end
      end
      StDEnd: begin
        // Hand memory to the core and prefetch the second instruction word.
        busy_d    = 1'b1;
        mem_sel_d = 1'b1;
        instr_adv = 1'b1;
        state_d   = StInstr;
      end
      StInstr: begin
        busy_d    = 1'b1;
        packet_d  = boot_make_pkt(CORE_ID_P, NetInstr, {16'b0, instr_rom_data_i},
                                  10'(instr_idx));
        instr_adv = 1'b1;
        if (instr_last) begin
          instr_clr = 1'b1;
          reg_adv   = 1'b1;
          state_d   = StReg;
        end
      end
      StReg: begin
        busy_d   = 1'b1;
        packet_d = boot_make_pkt(CORE_ID_P, NetReg, reg_rom_data_i[31:0],
                                 {4'b0, reg_rom_data_i[37:32]});
        reg_adv  = 1'b1;
        if (reg_last) begin
          reg_clr = 1'b1;
          state_d = StBar;
        end
      end
      StBar: begin
        busy_d   = 1'b1;
        packet_d = boot_make_pkt(CORE_ID_P, NetBar, BAR_MASK_P, BAR_ADDR_P);
        state_d  = StPc;
      end
      StPc: begin
        busy_d   = 1'b1;
        packet_d = boot_make_pkt(CORE_ID_P, NetPc, START_PC_P, 10'd0);
        state_d  = StDone;
      end
      StDone: begin
        if (start_i) begin
          state_d   = StLoadD;
          phase_d   = 1'b0;
          mem_sel_d = 1'b0;
          busy_d    = 1'b1;
        end else begin
          done_d   = 1'b1;
          packet_d = boot_make_pkt(CORE_ID_P, NetNull, boot_null_data_gp, BAR_ADDR_P);
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      phase_q    <= 1'b0;
      packet_q   <= '0;
      mem_q      <= '0;
      mem_addr_q <= '0;
      mem_sel_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      packet_q   <= packet_d;
      mem_q      <= mem_d;
      mem_addr_q <= mem_addr_d;
      mem_sel_q  <= mem_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign net_packet_flat_o = packet_q;
  assign mem_flat_o        = mem_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_sel_o         = mem_sel_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;

  // Register index comes from the ROM entry itself, not the stream position.
  assign unused_bits = ^{reg_idx, reg_rom_data_i[39:38]};

endmodule

// File: doc/core_boot_loader.md
Name: core_boot_loader

Overview:
- Hardware replacement for the bench-driven boot sequence of a single core.
- Streams three ROM images into the core: the data image is written straight into data memory through the mem_in_s port. Instruction and register images are sent as net_packet_s packets. Barrier-mask, PC and NULL packets follow.
- Sits upstream of core_flattened and data_mem. Drives the memory-ownership select, so the core takes over data memory once the data image is loaded.

Parameters:
- INSTR_WORDS_P, 1024, instruction image length (16-bit words).
- DATA_WORDS_P, 1024, data image length (32-bit words).
- REG_WORDS_P, 64, register image length; equals 2**rs_imm_size_gp.
- CORE_ID_P, 10'd1, ID field of every emitted packet.
- BAR_MASK_P, 32'h2, net_data of the BAR packet.
- BAR_ADDR_P, 10'd24, net_addr of the BAR and NULL packets.
- START_PC_P, 32'h5, net_data of the PC packet.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  begin boot; sampled in IDLE or DONE only.
- instr_rom_addr_o  out  $clog2(INSTR_WORDS_P)  instruction ROM address.
- instr_rom_data_i  in  16  instruction ROM data; synchronous read, 1-cycle latency.
- data_rom_addr_o  out  $clog2(DATA_WORDS_P)  data ROM address.
- data_rom_data_i  in  32  data ROM data; 1-cycle latency.
- reg_rom_addr_o  out  $clog2(REG_WORDS_P)  register ROM address.
- reg_rom_data_i  in  40  register ROM entry; [31:0] value, [37:32] register index.
- mem_flat_o  out  $bits(mem_in_s)  memory request used while loading data.
- mem_addr_o  out  32  byte address for mem_flat_o.
- mem_sel_o  out  1  1 = core owns data memory, 0 = loader owns it.
- net_packet_flat_o  out  $bits(net_packet_s)  registered packet to the core.
- busy_o  out  1  boot in progress.
- done_o  out  1  boot complete.

Behaviour:
- All outputs are registered.
- Reset values (reset=0, asynchronous, takes effect immediately even mid-boot):
  - state IDLE; all counters 0.
  - packet all-zero (net_op NULL, net_data 0).
  - mem_flat_o all-zero (valid=yumi=wen=0); mem_addr_o 0.
  - mem_sel_o 0, busy_o 0, done_o 0.
- States: IDLE -> LOAD_D -> D_END -> INSTR -> REG -> BAR -> PC -> DONE.
- start_i:
  - Moves IDLE to LOAD_D, and DONE to LOAD_D (restart).
  - Ignored in every other state.
  - busy_o=1 in LOAD_D through PC.
- LOAD_D:
  - Word k is presented for exactly one cycle: valid=yumi=wen=1, byte_not_word=0, mem_addr_o=4*k, write_data=data_rom[k].
  - This happens on cycle 2k+2 after the start_i cycle, with valid=0 on every intervening cycle.
  - The 2-cycle cadence covers the ROM read latency plus the memory write.
- D_END:
  - One cycle with valid=0.
  - mem_sel_o rises to 1 at the end of D_END and stays 1 until the next reset or restart.
- INSTR:
  - INSTR_WORDS_P packets on consecutive cycles with no gaps; ROM reads are prefetched one cycle ahead.
  - Packet k: ID=CORE_ID_P, net_op=INSTR, reserved=0, net_data={16'b0, instr_rom[k]}, net_addr=k.
- REG:
  - REG_WORDS_P packets back-to-back.
  - Each packet: net_op=REG, net_data=entry[31:0], net_addr zero-extended from entry[37:32].
- BAR: one packet, net_op=BAR, net_data=BAR_MASK_P, net_addr=BAR_ADDR_P.
- PC: one packet, net_op=PC, net_data=START_PC_P, net_addr=0.
- DONE:
  - NULL packet held indefinitely: net_data=32'hFFFFFFFE, net_addr=BAR_ADDR_P.
  - done_o=1, busy_o=0.
- Restart from DONE: mem_sel_o drops to 0 and done_o drops to 0 in the cycle after start_i.
- Counters:
  - Each counter is sized to its address width plus one bit so terminal counts compare exactly.
  - A counter wraps only on a state transition, never inside a state.
- Boundary: any *_WORDS_P=1 is legal and yields exactly one transfer in that phase.

Decomposition:
- Shared package (alongside definitions.sv):
  - boot_state_e enum.
  - boot_null_data_gp = 32'hFFFFFFFE.
- Existing net_packet_s, mem_in_s, net_op values and rs_imm_size_gp are reused unchanged.
- Sub-module boot_stream_ctr:
  - Parameterised by length.
  - Provides the address counter, the prefetch valid pipeline and a last flag.
  - Instantiated three times, once per image.

Test Plan:
- DATA=4, INSTR=4, REG=4, data ROM {11,22,33,44}, start at cycle 0 -> mem writes on cycles 2, 4, 6, 8 at addresses 0, 4, 8, 12 with those values; mem_sel_o=1 from cycle 10.
- Instruction ROM {16'h0841, 16'hFFFF, 16'h0000, 16'h1234} -> INSTR packets on 4 consecutive cycles; net_data 32'h00000841, 32'h0000FFFF, 32'h00000000, 32'h00001234; net_addr 0..3; ID 1.
- Register ROM entry 40'h3F_DEADBEEF -> REG packet with net_data 32'hDEADBEEF, net_addr 63.
- Sequence tail -> BAR (data 2, addr 24), then PC (data 5, addr 0), then NULL (data FFFFFFFE) held for 100 cycles with done_o=1 throughout.
- Reset asserted in the middle of INSTR -> all outputs take reset values immediately, with no further packets emitted. A fresh start_i reproduces the full sequence exactly.
- start_i pulsed during REG -> ignored, sequence unchanged. start_i pulsed in DONE -> full restart with mem_sel_o back to 0.
